fib_stream_checker: RTL and testbench

FIB_STREAM_CHECKER -- requirements
Module: fib_stream_checker

---
 rtl/fib_pkg.sv | 23 ++
 rtl/fib_stream_checker.sv | 142 ++++++++++++++
 tb/tb_fib_stream_checker.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci generator and stream checker.
package fib_pkg;

  localparam int FIB_W          = 8;
  localparam int PERIOD_W       = 5;
  localparam int SUM_W          = 12;
  localparam int FIB_WRAP_LIMIT = 255;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_SEED1 = 2'd1,
    ST_RUN   = 2'd2
  } fib_state_e;

  // Add a term to a running sum, clamping at the all-ones value.
  function automatic logic [SUM_W-1:0] sat_add_sum(input logic [SUM_W-1:0] acc,
                                                   input logic [FIB_W-1:0] term);
    logic [SUM_W:0] full;
    full = {1'b0, acc} + {{(SUM_W-FIB_W+1){1'b0}}, term};
    return full[SUM_W] ? {SUM_W{1'b1}} : full[SUM_W-1:0];
  endfunction

endpackage

// File: rtl/fib_stream_checker.sv
// Tracks an 8-bit Fibonacci stream, flags mismatching terms, counts errors
// and reports the length and sum of each complete period.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_HUNT  | waiting for a 0 to start a period; no errors reported
// ST_SEED1 | saw the leading 0, expecting the second seed term 1
// ST_RUN   | following the recurrence; a wrapped term (>255) expects 0
module fib_stream_checker
  import fib_pkg::*;
#(
  parameter int LOCK_TERMS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [FIB_W-1:0]    number,
  output logic                locked,
  output logic                err,
  output logic [7:0]          err_cnt,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic [SUM_W-1:0]    period_sum
);

  localparam logic [FIB_W:0] WRAP_LIMIT = (FIB_W+1)'(FIB_WRAP_LIMIT);
  localparam logic [3:0]     LOCK_THR   = 4'(LOCK_TERMS);

  fib_state_e          state;
  logic [FIB_W-1:0]    prev;
  logic [FIB_W-1:0]    prev2;
  logic [PERIOD_W-1:0] term_cnt;
  logic [SUM_W-1:0]    run_sum;
  logic [3:0]          consec;

  logic [FIB_W:0]      exp_sum;
  logic                exp_wrap;
  logic [FIB_W-1:0]    exp_term;
  logic [3:0]          consec_inc;
  logic [PERIOD_W-1:0] term_inc;
  logic [SUM_W-1:0]    run_sum_inc;
  logic [7:0]          err_cnt_inc;

  // Expected next term and saturating increments used by the FSM.
  always_comb begin
    exp_sum     = {1'b0, prev} + {1'b0, prev2};
    exp_wrap    = (exp_sum > WRAP_LIMIT);
    exp_term    = exp_wrap ? '0 : exp_sum[FIB_W-1:0];
    consec_inc  = (consec == 4'hF) ? consec : consec + 4'd1;
    term_inc    = (term_cnt == {PERIOD_W{1'b1}}) ? term_cnt : term_cnt + 1'b1;
    run_sum_inc = sat_add_sum(run_sum, number);
    err_cnt_inc = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
  end

  // Sequence-tracking FSM with registered outputs and saturating counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_HUNT;
      prev         <= '0;
      prev2        <= '0;
      term_cnt     <= '0;
      run_sum      <= '0;
      consec       <= '0;
      locked       <= 1'b0;
      err          <= 1'b0;
      err_cnt      <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      period_sum   <= '0;
    end else begin
      err          <= 1'b0;
      period_valid <= 1'b0;
      if (in_valid) begin
        case (state)
          ST_HUNT: begin
            if (number == '0) begin
              state    <= ST_SEED1;
              term_cnt <= PERIOD_W'(1);
              run_sum  <= '0;
            end
          end
          ST_SEED1: begin
            if (number == FIB_W'(1)) begin
              state    <= ST_RUN;
              prev2    <= '0;
              prev     <= FIB_W'(1);
              term_cnt <= PERIOD_W'(2);
              run_sum  <= SUM_W'(1);
              consec   <= consec_inc;
              locked   <= (consec_inc >= LOCK_THR);
            end else begin
              err     <= 1'b1;
              err_cnt <= err_cnt_inc;
              consec  <= '0;
              locked  <= 1'b0;
              if (number == '0) begin
                term_cnt <= PERIOD_W'(1);
                run_sum  <= '0;
              end else begin
                state <= ST_HUNT;
              end
            end
          end
          ST_RUN: begin
            if (number == exp_term) begin
              consec <= consec_inc;
              locked <= (consec_inc >= LOCK_THR);
              if (exp_wrap) begin
                // The 0 after the wrap closes this period and seeds the next.
                period_valid <= 1'b1;
                period       <= term_cnt;
                period_sum   <= run_sum;
                state        <= ST_SEED1;
                term_cnt     <= PERIOD_W'(1);
                run_sum      <= '0;
              end else begin
                prev2    <= prev;
                prev     <= number;
                term_cnt <= term_inc;
                run_sum  <= run_sum_inc;
              end
            end else begin
              err     <= 1'b1;
              err_cnt <= err_cnt_inc;
              consec  <= '0;
              locked  <= 1'b0;
              if (number == '0) begin
                state    <= ST_SEED1;
                term_cnt <= PERIOD_W'(1);
                run_sum  <= '0;
              end else begin
                state <= ST_HUNT;
              end
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fib_stream_checker.sv
// Directed testbench for fib_stream_checker.
module tb_fib_stream_checker;
  import fib_pkg::*;

  logic                clk;
  logic                reset;
  logic                in_valid;
  logic [FIB_W-1:0]    number;
  logic                locked;
  logic                err;
  logic [7:0]          err_cnt;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  logic [SUM_W-1:0]    period_sum;

  int checks = 0;
  int errors = 0;

  logic [7:0] seq [14] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                           8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233};

  fib_stream_checker #(.LOCK_TERMS(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .number(number),
    .locked(locked), .err(err), .err_cnt(err_cnt), .period(period),
    .period_valid(period_valid), .period_sum(period_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic [7:0] v, input logic vld);
    @(negedge clk);
    number   = v;
    in_valid = vld;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; number = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0d expected 0", locked); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0d expected 0", err); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
    checks++; if (period !== 5'd0) begin errors++; $display("FAIL reset_period: got %0d expected 0", period); end
    checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL reset_pv: got %0d expected 0", period_valid); end
    checks++; if (period_sum !== 12'd0) begin errors++; $display("FAIL reset_psum: got %0d expected 0", period_sum); end
  endtask

  task automatic test_nominal();
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      send(seq[i % 14], 1'b1);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL nom_err[%0d]: got %0d expected 0", i, err); end
      checks++; if (locked !== 1'(i >= 3)) begin errors++; $display("FAIL nom_locked[%0d]: got %0d expected %0d", i, locked, i >= 3); end
      checks++; if (period_valid !== 1'(i == 14 || i == 28)) begin errors++; $display("FAIL nom_pv[%0d]: got %0d expected %0d", i, period_valid, (i == 14 || i == 28)); end
      if (i == 14 || i == 28) begin
        checks++; if (period !== 5'd14) begin errors++; $display("FAIL nom_period[%0d]: got %0d expected 14", i, period); end
        checks++; if (period_sum !== 12'd609) begin errors++; $display("FAIL nom_psum[%0d]: got %0d expected 609", i, period_sum); end
      end
    end
  endtask

  task automatic test_mismatch();
    logic [7:0] bad  [5] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd4};
    logic [7:0] good [5] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3};
    apply_reset();
    for (int i = 0; i < 4; i++) send(bad[i], 1'b1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mm_prelock: got %0d expected 1", locked); end
    send(bad[4], 1'b1);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL mm_err: got %0d expected 1", err); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL mm_err_cnt: got %0d expected 1", err_cnt); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mm_locked: got %0d expected 0", locked); end
    for (int i = 0; i < 5; i++) begin
      send(good[i], 1'b1);
      // A 0 right after the mismatch only stays quiet if the checker is hunting.
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL mm_re_err[%0d]: got %0d expected 0", i, err); end
      checks++; if (locked !== 1'(i >= 3)) begin errors++; $display("FAIL mm_relock[%0d]: got %0d expected %0d", i, locked, i >= 3); end
    end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL mm_err_cnt_hold: got %0d expected 1", err_cnt); end
  endtask

  task automatic test_hold();
    apply_reset();
    for (int i = 0; i < 7; i++) send(seq[i], 1'b1);
    for (int i = 0; i < 5; i++) begin
      send(8'd99, 1'b0);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL hold_err[%0d]: got %0d expected 0", i, err); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL hold_locked[%0d]: got %0d expected 1", i, locked); end
      checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL hold_pv[%0d]: got %0d expected 0", i, period_valid); end
    end
    for (int i = 7; i <= 14; i++) begin
      send(seq[i % 14], 1'b1);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL hold_resume_err[%0d]: got %0d expected 0", i, err); end
      checks++; if (period_valid !== 1'(i == 14)) begin errors++; $display("FAIL hold_resume_pv[%0d]: got %0d expected %0d", i, period_valid, i == 14); end
    end
    checks++; if (period !== 5'd14) begin errors++; $display("FAIL hold_period: got %0d expected 14", period); end
    checks++; if (period_sum !== 12'd609) begin errors++; $display("FAIL hold_psum: got %0d expected 609", period_sum); end
  endtask

  task automatic test_saturate();
    apply_reset();
    // First 0 seeds; every further 0 in SEED1 is a mismatch.
    for (int i = 0; i < 300; i++) begin
      send(8'd0, 1'b1);
      checks++; if (err !== 1'(i >= 1)) begin errors++; $display("FAIL sat_err[%0d]: got %0d expected %0d", i, err, i >= 1); end
      checks++; if (err_cnt !== 8'((i > 255) ? 255 : i)) begin errors++; $display("FAIL sat_err_cnt[%0d]: got %0d expected %0d", i, err_cnt, (i > 255) ? 255 : i); end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 15; i++) send(seq[i % 14], 1'b1);
    for (int i = 1; i < 9; i++) send(seq[i], 1'b1);
    checks++; if (period !== 5'd14) begin errors++; $display("FAIL ar_pre_period: got %0d expected 14", period); end
    #3;
    reset = 1'b1;
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL ar_locked: got %0d expected 0", locked); end
    checks++; if (period !== 5'd0) begin errors++; $display("FAIL ar_period: got %0d expected 0", period); end
    checks++; if (period_sum !== 12'd0) begin errors++; $display("FAIL ar_psum: got %0d expected 0", period_sum); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL ar_err_cnt: got %0d expected 0", err_cnt); end
    @(negedge clk);
    reset = 1'b0;
    // Continuing the old period is ignored until a fresh 0 is seen.
    for (int i = 9; i < 14; i++) begin
      send(seq[i], 1'b1);
      checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL ar_trunc_pv[%0d]: got %0d expected 0", i, period_valid); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL ar_trunc_err[%0d]: got %0d expected 0", i, err); end
    end
    for (int i = 0; i <= 14; i++) begin
      send(seq[i % 14], 1'b1);
      checks++; if (period_valid !== 1'(i == 14)) begin errors++; $display("FAIL ar_pv[%0d]: got %0d expected %0d", i, period_valid, i == 14); end
    end
    checks++; if (period !== 5'd14) begin errors++; $display("FAIL ar_period_new: got %0d expected 14", period); end
    checks++; if (period_sum !== 12'd609) begin errors++; $display("FAIL ar_psum_new: got %0d expected 609", period_sum); end
  endtask

  task automatic test_late_start();
    apply_reset();
    for (int i = 5; i < 8; i++) begin
      send(seq[i], 1'b1);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL late_err[%0d]: got %0d expected 0", i, err); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL late_locked[%0d]: got %0d expected 0", i, locked); end
    end
    for (int i = 0; i <= 14; i++) begin
      send(seq[i % 14], 1'b1);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL late_run_err[%0d]: got %0d expected 0", i, err); end
      checks++; if (locked !== 1'(i >= 3)) begin errors++; $display("FAIL late_lock[%0d]: got %0d expected %0d", i, locked, i >= 3); end
    end
    checks++; if (period_valid !== 1'b1) begin errors++; $display("FAIL late_pv: got %0d expected 1", period_valid); end
    checks++; if (period !== 5'd14) begin errors++; $display("FAIL late_period: got %0d expected 14", period); end
    checks++; if (period_sum !== 12'd609) begin errors++; $display("FAIL late_psum: got %0d expected 609", period_sum); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL late_err_cnt: got %0d expected 0", err_cnt); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; number = '0;
    test_reset();
    test_nominal();
    test_mismatch();
    test_hold();
    test_saturate();
    test_async_reset();
    test_late_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
